// File: rtl/elelock_ctrl.sv
// rtl/elelock_ctrl.sv - ten-key electronic lock controller with code change and lockout
module elelock_ctrl #(
    parameter logic [15:0] DEFAULT_CODE = 16'h9634,
    parameter int          MAX_FAIL     = 3,
    parameter int          LOCKOUT_CYC  = 16
) (
    input  logic       ck,
    input  logic       reset,
    input  logic [9:0] tenkey,
    input  logic       enter,
    input  logic       set,
    input  logic       close,
    output logic       lock,
    output logic       lockout,
    output logic       setting,
    output logic [1:0] fail_cnt,
    output logic [2:0] digit_cnt
);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        SETCODE  = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam logic [15:0] TIMER_LOAD = 16'(LOCKOUT_CYC - 1);
    localparam logic [2:0]  FAIL_LIMIT = 3'(MAX_FAIL);

    state_t      state, state_d;
    logic [15:0] code_buf, code_buf_d;
    logic [15:0] code, code_d;
    logic [15:0] timer, timer_d;
    logic [2:0]  digit_cnt_d;
    logic [1:0]  fail_cnt_d;
    logic        lock_d, lockout_d, setting_d;

    logic [9:0]  prev_key;
    logic        prev_enter, prev_set;

    logic        key_onehot, digit_press, enter_press, set_press;
    logic [3:0]  digit;
    logic [15:0] shifted_buf;
    logic [2:0]  shifted_cnt;
    logic [2:0]  fail_inc;

    // Press detection: a single key from an all-released keypad, or a rising level.
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (tenkey[i]) digit = 4'(i);
        end
    end

    assign key_onehot  = (tenkey != 10'd0) && ((tenkey & (tenkey - 10'd1)) == 10'd0);
    assign digit_press = (prev_key == 10'd0) && key_onehot;
    assign enter_press = enter && !prev_enter;
    assign set_press   = set && !prev_set;
    assign shifted_buf = {code_buf[11:0], digit};
    assign shifted_cnt = (digit_cnt == 3'd4) ? 3'd4 : digit_cnt + 3'd1;
    assign fail_inc    = {1'b0, fail_cnt} + 3'd1;

    always_ff @(posedge ck) begin
        if (reset) begin
            state      <= LOCKED;
            code_buf   <= 16'h0000;
            code       <= DEFAULT_CODE;
            timer      <= 16'h0000;
            digit_cnt  <= 3'd0;
            fail_cnt   <= 2'd0;
            lock       <= 1'b1;
            lockout    <= 1'b0;
            setting    <= 1'b0;
            prev_key   <= 10'd0;
            prev_enter <= 1'b0;
            prev_set   <= 1'b0;
        end else begin
            state      <= state_d;
            code_buf   <= code_buf_d;
            code       <= code_d;
            timer      <= timer_d;
            digit_cnt  <= digit_cnt_d;
            fail_cnt   <= fail_cnt_d;
            lock       <= lock_d;
            lockout    <= lockout_d;
            setting    <= setting_d;
            prev_key   <= tenkey;
            prev_enter <= enter;
            prev_set   <= set;
        end
    end

    always_comb begin
        state_d     = state;
        code_buf_d  = code_buf;
        code_d      = code;
        timer_d     = timer;
        digit_cnt_d = digit_cnt;
        fail_cnt_d  = fail_cnt;
        case (state)
            LOCKED: begin
                if (digit_press) begin
                    code_buf_d  = shifted_buf;
                    digit_cnt_d = shifted_cnt;
                end
                // Enter judges the buffer including a digit pressed in the same cycle.
                if (enter_press) begin
                    if (digit_cnt_d == 3'd4 && code_buf_d == code) begin
                        state_d    = UNLOCKED;
                        fail_cnt_d = 2'd0;
                    end else begin
                        fail_cnt_d = fail_inc[1:0];
                        if (fail_inc == FAIL_LIMIT) begin
                            state_d = LOCKOUT;
                            timer_d = TIMER_LOAD;
                        end
                    end
                    code_buf_d  = 16'h0000;
                    digit_cnt_d = 3'd0;
                end
            end
            UNLOCKED: begin
                if (close) begin
                    state_d     = LOCKED;
                    code_buf_d  = 16'h0000;
                    digit_cnt_d = 3'd0;
                end else if (set_press) begin
                    state_d     = SETCODE;
                    code_buf_d  = 16'h0000;
                    digit_cnt_d = 3'd0;
                end
            end
            SETCODE: begin
                if (close) begin
                    state_d     = LOCKED;
                    code_buf_d  = 16'h0000;
                    digit_cnt_d = 3'd0;
                end else begin
                    if (digit_press) begin
                        code_buf_d  = shifted_buf;
                        digit_cnt_d = shifted_cnt;
                    end
                    if (enter_press) begin
                        if (digit_cnt_d == 3'd4) code_d = code_buf_d;
                        state_d     = UNLOCKED;
                        code_buf_d  = 16'h0000;
                        digit_cnt_d = 3'd0;
                    end
                end
            end
            LOCKOUT: begin
                // Timer is loaded with LOCKOUT_CYC-1 so the state lasts LOCKOUT_CYC cycles.
                if (timer == 16'h0000) begin
                    state_d    = LOCKED;
                    fail_cnt_d = 2'd0;
                end else begin
                    timer_d = timer - 16'h0001;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    // Decoded from the next state so the flags are registered alongside it.
    always_comb begin
        lock_d    = (state_d == LOCKED) || (state_d == LOCKOUT);
        lockout_d = (state_d == LOCKOUT);
        setting_d = (state_d == SETCODE);
    end

endmodule

// File: tb/tb_elelock_ctrl.sv
// tb/tb_elelock_ctrl.sv - directed self-checking bench for elelock_ctrl
module tb_elelock_ctrl;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] tenkey = 10'd0;
    logic       enter = 1'b0;
    logic       set = 1'b0;
    logic       close = 1'b0;
    logic       lock, lockout, setting;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;

    int tests = 0;
    int fails = 0;
    int lo_cycles = 0;
    logic count_en = 1'b0;

    elelock_ctrl dut (
        .ck        (ck),
        .reset     (reset),
        .tenkey    (tenkey),
        .enter     (enter),
        .set       (set),
        .close     (close),
        .lock      (lock),
        .lockout   (lockout),
        .setting   (setting),
        .fail_cnt  (fail_cnt),
        .digit_cnt (digit_cnt)
    );

    always #5 ck = ~ck;

    always @(negedge ck) begin
        if (count_en && lockout) lo_cycles = lo_cycles + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input int d);
        @(negedge ck) tenkey = 10'd1 << d;
        @(negedge ck) tenkey = 10'd0;
    endtask

    task automatic press_enter();
        @(negedge ck) enter = 1'b1;
        @(negedge ck) enter = 1'b0;
    endtask

    task automatic pulse_close();
        @(negedge ck) close = 1'b1;
        @(negedge ck) close = 1'b0;
    endtask

    task automatic pulse_set();
        @(negedge ck) set = 1'b1;
        @(negedge ck) set = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge ck) reset = 1'b1;
        @(negedge ck) reset = 1'b0;
    endtask

    task automatic entry(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(int'(c[i*4 +: 4]));
        press_enter();
    endtask

    task automatic check_idle_locked(input string tag);
        check({tag, "_lock"},    32'(lock),      32'd1);
        check({tag, "_lockout"}, 32'(lockout),   32'd0);
        check({tag, "_setting"}, 32'(setting),   32'd0);
        check({tag, "_fail"},    32'(fail_cnt),  32'd0);
        check({tag, "_digits"},  32'(digit_cnt), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge ck);
        reset = 1'b0;
        check_idle_locked("reset");

        // Correct default code.
        for (int d = 0; d < 4; d++) press(d == 0 ? 9 : d == 1 ? 6 : d == 2 ? 3 : 4);
        check("ok_digits4", 32'(digit_cnt), 32'd4);
        press_enter();
        check("ok_unlock", 32'(lock), 32'd0);
        check("ok_fail0", 32'(fail_cnt), 32'd0);
        check("ok_digits0", 32'(digit_cnt), 32'd0);
        pulse_close();
        check("ok_close", 32'(lock), 32'd1);

        // Six digits: only the last four count.
        press(8); press(5); press(9); press(6); press(3); press(4);
        check("ovf_digits", 32'(digit_cnt), 32'd4);
        press_enter();
        check("ovf_unlock", 32'(lock), 32'd0);
        pulse_close();
        check("ovf_close", 32'(lock), 32'd1);

        // Lockout after three wrong entries.
        entry(16'h1111);
        check("lo_fail1", 32'(fail_cnt), 32'd1);
        check("lo_lock1", 32'(lock), 32'd1);
        entry(16'h1111);
        check("lo_fail2", 32'(fail_cnt), 32'd2);
        count_en = 1'b1;
        entry(16'h1111);
        check("lo_active", 32'(lockout), 32'd1);
        check("lo_lock", 32'(lock), 32'd1);
        entry(16'h9634);
        check("lo_ignore_lock", 32'(lock), 32'd1);
        check("lo_ignore_digits", 32'(digit_cnt), 32'd0);
        begin
            int n = 0;
            while (lockout && n < 40) begin
                @(negedge ck);
                n++;
            end
            check("lo_expired", 32'(lockout), 32'd0);
        end
        count_en = 1'b0;
        check("lo_cycles", 32'(lo_cycles), 32'd16);
        check_idle_locked("lo_after");
        entry(16'h9634);
        check("lo_then_unlock", 32'(lock), 32'd0);

        // Code change to 1234.
        pulse_set();
        check("set_setting", 32'(setting), 32'd1);
        check("set_lock", 32'(lock), 32'd0);
        entry(16'h1234);
        check("set_done_setting", 32'(setting), 32'd0);
        check("set_done_lock", 32'(lock), 32'd0);
        pulse_close();
        check("set_close", 32'(lock), 32'd1);
        entry(16'h9634);
        check("old_code_fail", 32'(fail_cnt), 32'd1);
        check("old_code_lock", 32'(lock), 32'd1);
        entry(16'h1234);
        check("new_code_unlock", 32'(lock), 32'd0);
        check("new_code_fail0", 32'(fail_cnt), 32'd0);

        // Close beats set; abort of a code change; short entry keeps code.
        @(negedge ck) begin close = 1'b1; set = 1'b1; end
        @(negedge ck) begin close = 1'b0; set = 1'b0; end
        check("prio_lock", 32'(lock), 32'd1);
        check("prio_setting", 32'(setting), 32'd0);
        entry(16'h1234);
        pulse_set();
        press(5); press(6);
        check("abort_digits", 32'(digit_cnt), 32'd2);
        pulse_close();
        check("abort_lock", 32'(lock), 32'd1);
        check("abort_setting", 32'(setting), 32'd0);
        entry(16'h1234);
        check("abort_code_kept", 32'(lock), 32'd0);
        pulse_set();
        press(7);
        press_enter();
        check("short_setting", 32'(setting), 32'd0);
        check("short_lock", 32'(lock), 32'd0);
        pulse_close();
        entry(16'h1234);
        check("short_code_kept", 32'(lock), 32'd0);
        pulse_close();

        // Held key and multi-key input.
        @(negedge ck) tenkey = 10'b10_0000_0000;
        repeat (4) @(negedge ck);
        tenkey = 10'd0;
        @(negedge ck);
        check("held_digits", 32'(digit_cnt), 32'd1);
        @(negedge ck) tenkey = 10'b00_0000_0011;
        @(negedge ck) tenkey = 10'd0;
        check("multi_digits", 32'(digit_cnt), 32'd1);
        press_enter();
        check("held_fail", 32'(fail_cnt), 32'd1);

        // Last digit and enter in the same cycle.
        press(1); press(2); press(3);
        @(negedge ck) begin tenkey = 10'd1 << 4; enter = 1'b1; end
        @(negedge ck) begin tenkey = 10'd0; enter = 1'b0; end
        check("same_cycle_unlock", 32'(lock), 32'd0);
        check("same_cycle_fail0", 32'(fail_cnt), 32'd0);

        // Reset during SETCODE restores the default code.
        pulse_set();
        press(5);
        check("rst_set_pre", 32'(setting), 32'd1);
        pulse_reset();
        check_idle_locked("rst_set");
        entry(16'h9634);
        check("rst_default_code", 32'(lock), 32'd0);
        pulse_close();

        // Reset during LOCKOUT.
        entry(16'h0000); entry(16'h0000); entry(16'h0000);
        check("rst_lo_pre", 32'(lockout), 32'd1);
        pulse_reset();
        check_idle_locked("rst_lo");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elelock_ctrl.md
ELELOCK_CTRL -- requirements
Module: elelock_ctrl

Interface
REQ-001 Parameter DEFAULT_CODE, 16'h9634, power-on code as four BCD digits; the most significant nibble is the first digit entered.
REQ-002 Parameter MAX_FAIL, 3, number of consecutive wrong entries that triggers lockout (range 1-3).
REQ-003 Parameter LOCKOUT_CYC, 16, lockout duration in clock cycles (range 1-65535).
REQ-004 ck  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tenkey  in  10  key levels; bit n high means digit n is held.
REQ-007 enter  in  1  enter-key level.
REQ-008 set  in  1  code-change request level.
REQ-009 close  in  1  close request level; acted on in every cycle it is high.
REQ-010 lock  out  1  1 = locked.
REQ-011 lockout  out  1  1 = lockout period active.
REQ-012 setting  out  1  1 = code-change mode.
REQ-013 fail_cnt  out  2  count of consecutive wrong entries.
REQ-014 digit_cnt  out  3  digits buffered, saturating at 4.

Function
REQ-015 Every output shall be driven directly from a register.
REQ-016 A digit press shall be detected in the cycle where the registered previous tenkey is all-zero and the current tenkey is exactly one-hot; its value is the index of the set bit.
REQ-017 Multi-bit or repeated (held) tenkey patterns shall be ignored.
REQ-018 An enter press or set press shall be detected on the 0->1 edge against the registered previous value.
REQ-019 States: LOCKED, UNLOCKED, SETCODE, LOCKOUT.
REQ-020 Outputs per state:
- lock = 1 in LOCKED and LOCKOUT; lock = 0 in UNLOCKED and SETCODE.
- setting = 1 only in SETCODE.
- lockout = 1 only in LOCKOUT.
REQ-021 In LOCKED and SETCODE, a digit press shall:
- shift the digit into the 16-bit buffer as buf <= {buf[11:0], digit};
- increment digit_cnt, saturating at 4.
REQ-022 LOCKED, enter press with digit_cnt==4 and buf==code: go to UNLOCKED on that same edge and clear fail_cnt.
REQ-023 LOCKED, any other enter press: increment fail_cnt.
- If the new count equals MAX_FAIL, go to LOCKOUT and load the timer so that lockout stays high for exactly LOCKOUT_CYC cycles.
REQ-024 Every enter press, whatever its outcome, shall clear buf and digit_cnt.
REQ-025 In LOCKED, close and set shall be ignored.
REQ-026 In UNLOCKED:
- close shall go to LOCKED, with buf and digit_cnt cleared.
- A set press shall go to SETCODE.
- Digit and enter presses shall be ignored.
REQ-027 In UNLOCKED, close shall take priority over a set press in the same cycle.
REQ-028 In SETCODE, an enter press with digit_cnt==4 shall load code <= buf and return to UNLOCKED.
REQ-029 In SETCODE, an enter press with digit_cnt<4 shall return to UNLOCKED with code unchanged.
REQ-030 In SETCODE, close shall go to LOCKED with code unchanged, taking priority over an enter press in the same cycle.
REQ-031 In LOCKOUT, all key, enter, set and close inputs shall be ignored.
- The timer decrements once per cycle.
- On expiry, go to LOCKED with fail_cnt=0.
REQ-032 A digit press and an enter press in the same cycle: the digit is shifted in first, and the enter press evaluates the updated buffer and count.
REQ-033 Edge-detect history registers shall update in every state, including LOCKOUT, so a key held across a state change does not produce a press.

Reset
REQ-034 When reset is high at a rising edge, the block shall return to its reset values, overriding all other inputs and interrupting any state or timer:
- state = LOCKED; lock=1, lockout=0, setting=0;
- fail_cnt=0, digit_cnt=0, buf=0, timer=0;
- code=DEFAULT_CODE;
- edge-detect history = 0.
REQ-035 A custom code loaded in SETCODE shall not survive reset.

Verification
REQ-036 Correct code: after reset, press 9,6,3,4 then enter -> lock goes 0 on the edge that samples enter; fail_cnt=0.
REQ-037 Digit overflow: press 8,5,9,6,3,4 then enter -> digit_cnt shows 4, buf=16'h9634, lock=0; then close high for 1 cycle -> lock=1 on the next edge.
REQ-038 Lockout: three entries of 1,1,1,1 + enter -> fail_cnt goes 1, 2; lockout=1 for exactly 16 cycles; a correct entry made during lockout is ignored; afterwards LOCKED with fail_cnt=0.
REQ-039 Code change: unlock; set; press 1,2,3,4; enter -> UNLOCKED. Then close; entering 9634 fails (fail_cnt=1); entering 1234 unlocks.
REQ-040 Priority and abort:
- In UNLOCKED, close and a set press in the same cycle -> LOCKED, setting stays 0.
- In SETCODE after 2 digits, close -> LOCKED with code unchanged.
REQ-041 Held and multi-key input: holding tenkey[9] for 4 cycles -> digit_cnt=1; tenkey=10'b0000000011 -> no press.
REQ-042 Reset mid-operation: reset asserted during LOCKOUT and during SETCODE -> all outputs and code return to their reset values on the next edge.
